// File: rtl/control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : control_pipe
// Purpose  : Registered, flow-controlled A64 main decoder. Accepts 32-bit
//            instructions over valid/ready, decodes the 16-bit control
//            bundle, buffers {instr, ctl} in a small skid FIFO, holds off
//            load-use hazards after LDUR and supports a single-cycle flush.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous active-high reset
//   in_valid     in   1      instruction presented
//   in_ready     out  1      instruction accepted when in_valid && in_ready
//   in_instr     in   32     instruction word
//   flush        in   1      discard buffered and incoming work this cycle
//   out_valid    out  1      FIFO head holds a bundle
//   out_ready    in   1      consumer takes head when out_valid && out_ready
//   out_instr    out  32     instruction word of head
//   out_ctl      out  16     control bundle of head
//   stall_cycles out  CNT_W  saturating count of interlock cycles
// ============================================================================
module control_pipe #(
  parameter int SKID_DEPTH = 2,
  parameter int LOAD_LAT   = 1,
  parameter bit ENABLE_MEM = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [15:0]      out_ctl,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int PTR_W = $clog2(SKID_DEPTH);
  localparam int OCC_W = $clog2(SKID_DEPTH) + 1;

  // Control bundle bit positions
  localparam int B_ILLEGAL    = 15;
  localparam int B_USE_SP     = 14;
  localparam int B_REG_WRITE  = 13;
  localparam int B_ALU_OP_HI  = 12;
  localparam int B_ALU_OP_LO  = 11;
  localparam int B_ALU_SRC    = 10;
  localparam int B_FLAG_WRITE = 9;
  localparam int B_MEM_WRITE  = 8;
  localparam int B_MEM_TO_REG = 7;
  localparam int B_MEM_READ   = 6;
  localparam int B_NZ_BRANCH  = 5;
  localparam int B_Z_BRANCH   = 4;
  localparam int B_FLAG_BR    = 3;
  localparam int B_UNCOND_BR  = 2;
  localparam int B_REG2LOC    = 1;

  logic [15:0]      dec_ctl;
  logic             reads_rn;
  logic             reads_rm;
  logic             reads_rt;
  logic             is_ldur;
  logic [4:0]       fld_rn;
  logic [4:0]       fld_rm;
  logic [4:0]       fld_rt;

  logic [31:0]      instr_mem [SKID_DEPTH];
  logic [15:0]      ctl_mem   [SKID_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occupancy;
  logic [1:0]       ld_cnt;
  logic [4:0]       ld_rt;

  logic             full;
  logic             src_hit;
  logic             interlock;
  logic             push;
  logic             pop;

  assign fld_rn = in_instr[9:5];
  assign fld_rm = in_instr[20:16];
  assign fld_rt = in_instr[4:0];

  // First-match decode; also reports which source fields the op reads.
  always_comb begin
    dec_ctl  = '0;
    reads_rn = 1'b0;
    reads_rm = 1'b0;
    reads_rt = 1'b0;
    is_ldur  = 1'b0;
    if (in_instr[31:24] == 8'hB4) begin
      dec_ctl[B_REG2LOC]                  = 1'b1;
      dec_ctl[B_Z_BRANCH]                 = 1'b1;
      dec_ctl[B_ALU_OP_HI:B_ALU_OP_LO]    = 2'b01;
      reads_rt                            = 1'b1;
    end else if (in_instr[31:24] == 8'hB5) begin
      dec_ctl[B_REG2LOC]                  = 1'b1;
      dec_ctl[B_NZ_BRANCH]                = 1'b1;
      dec_ctl[B_ALU_OP_HI:B_ALU_OP_LO]    = 2'b01;
      reads_rt                            = 1'b1;
    end else if (in_instr[31:26] == 6'b000101) begin
      dec_ctl[B_UNCOND_BR]                = 1'b1;
    end else if (in_instr[31:24] == 8'h54 && !in_instr[4]) begin
      dec_ctl[B_FLAG_BR]                  = 1'b1;
    end else if (in_instr[31:23] == 9'h1A5) begin
      dec_ctl[B_REG_WRITE]                = 1'b1;
      dec_ctl[B_ALU_SRC]                  = 1'b1;
    end else if (in_instr[31:21] == 11'h758 && fld_rt == 5'd31) begin
      dec_ctl[B_FLAG_WRITE]               = 1'b1;
      dec_ctl[B_ALU_OP_HI:B_ALU_OP_LO]    = 2'b01;
      reads_rn                            = 1'b1;
      reads_rm                            = 1'b1;
    end else if (in_instr[31:23] == 9'h1A2 || in_instr[31:23] == 9'h122) begin
      dec_ctl[B_ALU_OP_HI:B_ALU_OP_LO]    = 2'b10;
      dec_ctl[B_ALU_SRC]                  = 1'b1;
      dec_ctl[B_USE_SP]                   = 1'b1;
      dec_ctl[B_REG_WRITE]                = 1'b1;
      reads_rn                            = 1'b1;
    end else if (ENABLE_MEM && in_instr[31:21] == 11'h7C2) begin
      dec_ctl[B_MEM_READ]                 = 1'b1;
      dec_ctl[B_MEM_TO_REG]               = 1'b1;
      dec_ctl[B_ALU_SRC]                  = 1'b1;
      dec_ctl[B_REG_WRITE]                = 1'b1;
      dec_ctl[B_USE_SP]                   = 1'b1;
      reads_rn                            = 1'b1;
      is_ldur                             = 1'b1;
    end else if (ENABLE_MEM && in_instr[31:21] == 11'h7C0) begin
      dec_ctl[B_MEM_WRITE]                = 1'b1;
      dec_ctl[B_REG2LOC]                  = 1'b1;
      dec_ctl[B_ALU_SRC]                  = 1'b1;
      dec_ctl[B_USE_SP]                   = 1'b1;
      reads_rn                            = 1'b1;
      reads_rt                            = 1'b1;
    end else begin
      dec_ctl[B_ILLEGAL]                  = 1'b1;
    end
  end

  // X31 is the zero/SP register and never creates a dependency.
  assign src_hit = (reads_rn && fld_rn != 5'd31 && fld_rn == ld_rt) ||
                   (reads_rm && fld_rm != 5'd31 && fld_rm == ld_rt) ||
                   (reads_rt && fld_rt != 5'd31 && fld_rt == ld_rt);

  assign interlock = (ld_cnt != 2'd0) && in_valid && src_hit;
  assign full      = (occupancy == OCC_W'(SKID_DEPTH));
  assign in_ready  = !full && !interlock && !rst;
  assign push      = in_valid && in_ready && !flush;
  assign out_valid = (occupancy != '0);
  assign pop       = out_valid && out_ready;

  // Head is read straight from FIFO storage; forced to zero when empty so
  // reset and flush present a clean all-zero bundle.
  assign out_instr = out_valid ? instr_mem[rd_ptr] : 32'd0;
  assign out_ctl   = out_valid ? ctl_mem[rd_ptr]   : 16'd0;

  // Storage needs no reset: contents are qualified by occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= in_instr;
      ctl_mem[wr_ptr]   <= dec_ctl;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      ld_cnt       <= 2'd0;
      ld_rt        <= 5'd0;
      stall_cycles <= '0;
    end else begin
      // Stall accounting survives flush.
      if (interlock && stall_cycles != {CNT_W{1'b1}}) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occupancy <= '0;
        ld_cnt    <= 2'd0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push && !pop) begin
          occupancy <= occupancy + OCC_W'(1);
        end else if (!push && pop) begin
          occupancy <= occupancy - OCC_W'(1);
        end
        // A newer load always replaces the tracked one.
        if (push && is_ldur && fld_rt != 5'd31) begin
          ld_rt  <= fld_rt;
          ld_cnt <= 2'(LOAD_LAT);
        end else if (ld_cnt != 2'd0) begin
          ld_cnt <= ld_cnt - 2'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_control_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_control_pipe
// Purpose  : Self-checking bench for control_pipe: directed scenarios plus a
//            randomized run against a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_pipe;

  localparam int LAT = 1;
  localparam int DEPTH = 2;

  localparam logic [31:0] I_ADD    = 32'h91001041;
  localparam logic [31:0] I_LDUR   = 32'hF8400041;
  localparam logic [31:0] I_ADDDEP = 32'h91000423;
  localparam logic [31:0] I_MOVZ   = 32'hD2800020;
  localparam logic [31:0] I_CMP    = 32'hEB02003F;
  localparam logic [31:0] I_CBZ    = 32'hB4000045;
  localparam logic [31:0] I_BEQ    = 32'h54000040;

  // Expected bundles (bit15..bit1 = illegal,use_sp,reg_write,alu_op[1:0],
  // alu_src,flag_write,mem_write,mem_to_reg,mem_read,nzb,zb,fb,ub,reg2loc)
  localparam logic [15:0] C_ADD  = 16'h7400;
  localparam logic [15:0] C_LDUR = 16'h64C0;
  localparam logic [15:0] C_STUR = 16'h4502;
  localparam logic [15:0] C_CMP  = 16'h0A00;
  localparam logic [15:0] C_CBZ  = 16'h0812;
  localparam logic [15:0] C_CBNZ = 16'h0822;
  localparam logic [15:0] C_B    = 16'h0004;
  localparam logic [15:0] C_BC   = 16'h0008;
  localparam logic [15:0] C_MOVZ = 16'h2400;
  localparam logic [15:0] C_ILL  = 16'h8000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
  logic [31:0] in_instr = '0, out_instr;
  logic [15:0] out_ctl;
  logic [15:0] stall_cycles;

  logic        x_valid = 1'b0, x_flush = 1'b0, x_out_ready = 1'b0;
  logic [31:0] x_instr = '0;
  logic        nm_in_ready, nm_out_valid, sat_in_ready, sat_out_valid;
  logic [31:0] nm_out_instr, sat_out_instr;
  logic [15:0] nm_out_ctl, sat_out_ctl;
  logic [15:0] nm_stall;
  logic [1:0]  sat_stall;

  int checks = 0;
  int passes = 0;

  logic [31:0] got_i[$];
  logic [15:0] got_c[$];

  control_pipe #(.SKID_DEPTH(DEPTH), .LOAD_LAT(LAT), .ENABLE_MEM(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_ctl(out_ctl), .stall_cycles(stall_cycles));

  control_pipe #(.SKID_DEPTH(2), .LOAD_LAT(1), .ENABLE_MEM(1'b0), .CNT_W(16)) dut_nm (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(nm_in_ready), .in_instr(x_instr),
    .flush(x_flush), .out_valid(nm_out_valid), .out_ready(x_out_ready), .out_instr(nm_out_instr),
    .out_ctl(nm_out_ctl), .stall_cycles(nm_stall));

  control_pipe #(.SKID_DEPTH(2), .LOAD_LAT(3), .ENABLE_MEM(1'b1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(sat_in_ready), .in_instr(x_instr),
    .flush(x_flush), .out_valid(sat_out_valid), .out_ready(x_out_ready), .out_instr(sat_out_instr),
    .out_ctl(sat_out_ctl), .stall_cycles(sat_stall));

  // Record every bundle the consumer takes from the main DUT.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got_i.push_back(out_instr);
      got_c.push_back(out_ctl);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_instr = '0;
    x_valid = 1'b0; x_flush = 1'b0; x_out_ready = 1'b0; x_instr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_i.delete();
    got_c.delete();
  endtask

  // Present one word on the main port until accepted (bounded).
  task automatic push_one(input logic [31:0] w, output int waits);
    in_valid = 1'b1;
    in_instr = w;
    waits = 0;
    #1;
    while (!in_ready && waits < 20) begin
      step();
      waits++;
    end
    step();
    in_valid = 1'b0;
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  // Builds a random instruction of a chosen class together with its expected
  // bundle, the registers it reads (31 = none) and the load target (31 = none).
  function automatic void gen(output logic [31:0] w, output logic [15:0] c,
                              output logic [4:0] s0, output logic [4:0] s1,
                              output logic [4:0] lrt);
    logic [4:0] a, b, d;
    a = pick_reg(); b = pick_reg(); d = pick_reg();
    s0 = 5'd31; s1 = 5'd31; lrt = 5'd31;
    case ($urandom_range(0, 10))
      0:  begin w = {9'h122, 13'($urandom), a, d}; c = C_ADD; s0 = a; end
      1:  begin w = {9'h1A2, 13'($urandom), a, d}; c = C_ADD; s0 = a; end
      2:  begin w = {11'h758, b, 6'($urandom), a, 5'd31}; c = C_CMP; s0 = a; s1 = b; end
      3:  begin w = {11'h7C2, 11'($urandom), a, d}; c = C_LDUR; s0 = a; lrt = d; end
      4:  begin w = {11'h7C0, 11'($urandom), a, b}; c = C_STUR; s0 = a; s1 = b; end
      5:  begin w = {8'hB4, 19'($urandom), b}; c = C_CBZ; s0 = b; end
      6:  begin w = {8'hB5, 19'($urandom), b}; c = C_CBNZ; s0 = b; end
      7:  begin w = {6'b000101, 26'($urandom)}; c = C_B; end
      8:  begin w = {8'h54, 19'($urandom), 1'b0, 4'($urandom)}; c = C_BC; end
      9:  begin w = {9'h1A5, 23'($urandom)}; c = C_MOVZ; end
      default: begin w = {8'h00, 24'($urandom)}; c = C_ILL; end
    endcase
  endfunction

  task automatic test_reset();
    int w;
    do_reset();
    push_one(I_ADD, w);
    #2 rst = 1'b1;
    in_valid = 1'b1; in_instr = I_ADD;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b required 0", in_ready); else passes++;
    checks++; if (out_instr !== 32'd0 || out_ctl !== 16'd0) $display("FAIL reset_out_bundle: got %h/%h required 0/0", out_instr, out_ctl); else passes++;
    checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall: got %0d required 0", stall_cycles); else passes++;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b required 1", in_ready); else passes++;
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) $display("FAIL reset_first_accept: got %b required 1", out_valid); else passes++;
  endtask

  task automatic test_add();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = I_ADD;
    #1;
    checks++; if (in_ready !== 1'b1) $display("FAIL add_ready: got %b required 1", in_ready); else passes++;
    step();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL add_latency: got %b required 1", out_valid); else passes++;
    checks++; if (out_ctl !== C_ADD) $display("FAIL add_ctl: got %h required %h", out_ctl, C_ADD); else passes++;
    checks++; if (out_instr !== I_ADD) $display("FAIL add_instr: got %h required %h", out_instr, I_ADD); else passes++;
    step();
    checks++; if (out_valid !== 1'b0) $display("FAIL add_drained: got %b required 0", out_valid); else passes++;
  endtask

  task automatic test_load_use();
    int w0, w1;
    do_reset();
    out_ready = 1'b1;
    push_one(I_LDUR, w0);
    push_one(I_ADDDEP, w1);
    repeat (3) step();
    checks++; if (w1 !== 1) $display("FAIL load_use_stall_len: got %0d required 1", w1); else passes++;
    checks++; if (stall_cycles !== 16'd1) $display("FAIL load_use_counter: got %0d required 1", stall_cycles); else passes++;
    checks++;
    if (got_i.size() != 2 || got_i[0] !== I_LDUR || got_i[1] !== I_ADDDEP || got_c[0] !== C_LDUR)
      $display("FAIL load_use_order: got %0d bundles required 2 (LDUR ctl %h then ADD)", got_i.size(), C_LDUR);
    else passes++;
  endtask

  task automatic test_no_stall();
    int w0, w1;
    do_reset();
    out_ready = 1'b1;
    push_one(I_LDUR, w0);
    push_one(I_MOVZ, w1);
    step();
    checks++; if (w1 !== 0) $display("FAIL no_stall_wait: got %0d required 0", w1); else passes++;
    checks++; if (stall_cycles !== 16'd0) $display("FAIL no_stall_counter: got %0d required 0", stall_cycles); else passes++;
  endtask

  task automatic test_fifo_full_order();
    int w;
    do_reset();
    push_one(I_CMP, w);
    push_one(I_CBZ, w);
    in_valid = 1'b1; in_instr = I_BEQ;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b required 0", in_ready); else passes++;
    repeat (2) step();
    checks++; if (out_instr !== I_CMP || out_ctl !== C_CMP) $display("FAIL full_head_hold: got %h/%h required %h/%h", out_instr, out_ctl, I_CMP, C_CMP); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL full_ready_held: got %b required 0", in_ready); else passes++;
    got_i.delete(); got_c.delete();
    out_ready = 1'b1;
    push_one(I_BEQ, w);
    repeat (4) step();
    checks++;
    if (got_i.size() != 3 || got_i[0] !== I_CMP || got_i[1] !== I_CBZ || got_i[2] !== I_BEQ ||
        got_c[1] !== C_CBZ || got_c[2] !== C_BC)
      $display("FAIL full_drain_order: got %0d bundles required 3 (CMP, CBZ %h, B.EQ %h)", got_i.size(), C_CBZ, C_BC);
    else passes++;
  endtask

  task automatic test_flush();
    int w;
    do_reset();
    push_one(I_ADD, w);
    push_one(I_LDUR, w);
    in_valid = 1'b1; in_instr = I_MOVZ; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_empty: got %b required 0", out_valid); else passes++;
    got_i.delete(); got_c.delete();
    out_ready = 1'b1;
    repeat (3) step();
    checks++; if (got_i.size() != 0) $display("FAIL flush_dropped: got %0d bundles required 0", got_i.size()); else passes++;
    // Outstanding load with three stall cycles left must be forgotten.
    x_out_ready = 1'b1;
    x_valid = 1'b1; x_instr = I_LDUR;
    step();
    x_instr = I_ADDDEP; x_flush = 1'b1;
    #1;
    checks++; if (sat_in_ready !== 1'b0) $display("FAIL flush_pre_interlock: got %b required 0", sat_in_ready); else passes++;
    step();
    x_flush = 1'b0;
    #1;
    checks++; if (sat_in_ready !== 1'b1) $display("FAIL flush_ld_cnt: got %b required 1", sat_in_ready); else passes++;
    step();
    x_valid = 1'b0;
  endtask

  task automatic test_illegal();
    int w;
    do_reset();
    push_one(32'h00000000, w);
    checks++; if (out_ctl !== C_ILL || out_instr !== 32'd0) $display("FAIL illegal_zero: got %h required %h", out_ctl, C_ILL); else passes++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    push_one(32'hEB020020, w);
    checks++; if (out_ctl !== C_ILL) $display("FAIL illegal_cmp_rd: got %h required %h", out_ctl, C_ILL); else passes++;
  endtask

  task automatic test_nomem();
    do_reset();
    x_valid = 1'b1; x_instr = I_LDUR;
    step();
    x_instr = I_ADDDEP;
    #1;
    checks++; if (nm_in_ready !== 1'b1) $display("FAIL nomem_no_interlock: got %b required 1", nm_in_ready); else passes++;
    checks++; if (nm_out_ctl !== C_ILL || nm_out_instr !== I_LDUR) $display("FAIL nomem_ldur_illegal: got %h required %h", nm_out_ctl, C_ILL); else passes++;
    step();
    x_valid = 1'b0;
    checks++; if (nm_stall !== 16'd0) $display("FAIL nomem_stall: got %0d required 0", nm_stall); else passes++;
  endtask

  task automatic test_saturation();
    int w;
    do_reset();
    x_out_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      x_valid = 1'b1; x_instr = I_LDUR;
      step();
      x_instr = I_ADDDEP;
      #1;
      w = 0;
      while (!sat_in_ready && w < 10) begin
        step();
        w++;
      end
      step();
      x_valid = 1'b0;
      checks++; if (w !== 3) $display("FAIL sat_stall_len%0d: got %0d required 3", rep, w); else passes++;
      checks++; if (sat_stall !== 2'b11) $display("FAIL sat_counter%0d: got %0d required 3", rep, sat_stall); else passes++;
    end
  endtask

  task automatic test_random();
    logic [31:0] mq_i[$];
    logic [15:0] mq_c[$];
    logic [31:0] w;
    logic [15:0] c;
    logic [4:0]  s0, s1, lrt, ld_rt;
    bit          ld_ok, live, haz, exp_rdy, acc;
    int          ld_cyc, m_stall;
    ld_ok = 0; ld_cyc = 0; ld_rt = 5'd31; m_stall = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if (out_valid !== (mq_i.size() != 0)) $display("FAIL rnd_valid@%0d: got %b required %b", cyc, out_valid, mq_i.size() != 0); else passes++;
      if (mq_i.size() != 0) begin
        checks++; if (out_instr !== mq_i[0] || out_ctl !== mq_c[0]) $display("FAIL rnd_head@%0d: got %h/%h required %h/%h", cyc, out_instr, out_ctl, mq_i[0], mq_c[0]); else passes++;
      end
      checks++; if (stall_cycles !== 16'(m_stall)) $display("FAIL rnd_stall@%0d: got %0d required %0d", cyc, stall_cycles, m_stall); else passes++;
      gen(w, c, s0, s1, lrt);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = w;
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      // A load blocks readers of its target during the LAT cycles after acceptance.
      live = ld_ok && (cyc > ld_cyc) && (cyc <= ld_cyc + LAT);
      haz  = live && in_valid && ((s0 != 5'd31 && s0 == ld_rt) || (s1 != 5'd31 && s1 == ld_rt));
      exp_rdy = (mq_i.size() < DEPTH) && !haz;
      checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready@%0d: got %b required %b", cyc, in_ready, exp_rdy); else passes++;
      if (haz) m_stall++;
      acc = in_valid && exp_rdy && !flush;
      if (flush) begin
        mq_i.delete(); mq_c.delete();
        ld_ok = 0;
      end else begin
        if (mq_i.size() != 0 && out_ready) begin
          void'(mq_i.pop_front());
          void'(mq_c.pop_front());
        end
        if (acc) begin
          mq_i.push_back(w);
          mq_c.push_back(c);
          if (lrt != 5'd31) begin
            ld_ok = 1; ld_cyc = cyc; ld_rt = lrt;
          end
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_no_stall();
    test_fifo_full_order();
    test_flush();
    test_illegal();
    test_nomem();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
